// File: rtl/logic_gate_array_reg.sv
// Registered multi-channel bitwise gate unit with optional multi-beat folding.
// One result per single beat or per closed group, latency 1, valid/ready both sides.

module logic_gate_array_reg_lane #(
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0] bits,
    input  logic [2:0]        op,
    output logic              red
);
    // Base reduction of one bit position across all channels; inversion is applied later.
    always_comb begin
        red = 1'b0;
        case (op)
            3'b000, 3'b011: red = &bits;
            3'b001, 3'b100: red = |bits;
            3'b010, 3'b101: red = ^bits;
            3'b110:         red = bits[0];
            default:        red = 1'b0;
        endcase
    end
endmodule

module logic_gate_array_reg #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [2:0]              in_op,
    input  logic                    in_acc,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_any,
    output logic                    out_all,
    output logic [7:0]              out_beats
);
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                         state;
    logic [WIDTH-1:0]               acc;
    logic [2:0]                     grp_op;
    logic [7:0]                     beats;

    logic [NUM_IN-1:0][WIDTH-1:0]   ch;
    logic [2:0]                     beat_op;
    logic [WIDTH-1:0]               beat_red;
    logic [WIDTH-1:0]               acc_fold;
    logic [WIDTH-1:0]               res;
    logic [WIDTH-1:0]               res_out;
    logic [7:0]                     beats_inc;
    logic [7:0]                     res_beats;
    logic                           accept;
    logic                           inv;

    assign ch       = in_data;
    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // Inside a group the latched op governs both the beat reduce and the fold.
    assign beat_op  = (state == ACCUM) ? grp_op : in_op;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [NUM_IN-1:0] col;
        for (genvar k = 0; k < NUM_IN; k++) begin : g_ch
            assign col[k] = ch[k][b];
        end
        logic_gate_array_reg_lane #(.NUM_IN(NUM_IN)) u_lane (
            .bits (col),
            .op   (beat_op),
            .red  (beat_red[b])
        );
    end

    always_comb begin
        acc_fold = '0;
        case (grp_op)
            3'b000, 3'b011: acc_fold = acc & beat_red;
            3'b001, 3'b100: acc_fold = acc | beat_red;
            3'b010, 3'b101: acc_fold = acc ^ beat_red;
            3'b110:         acc_fold = acc;
            default:        acc_fold = '0;
        endcase
    end

    assign inv       = (beat_op == 3'b011) || (beat_op == 3'b100) || (beat_op == 3'b101);
    assign beats_inc = (beats == 8'hFF) ? beats : beats + 8'd1;
    assign res       = (state == ACCUM) ? acc_fold : beat_red;
    assign res_out   = inv ? ~res : res;
    assign res_beats = (state == ACCUM) ? beats_inc : 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            grp_op    <= '0;
            beats     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_any   <= 1'b0;
            out_all   <= 1'b0;
            out_beats <= '0;
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                if ((state == IDLE && in_acc && !in_last) || (state == ACCUM && !in_last)) begin
                    acc    <= res;
                    beats  <= res_beats;
                    state  <= ACCUM;
                    if (state == IDLE)
                        grp_op <= in_op;
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= res_out;
                    out_any   <= |res_out;
                    out_all   <= &res_out;
                    out_beats <= res_beats;
                    state     <= IDLE;
                    acc       <= '0;
                    grp_op    <= '0;
                    beats     <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_logic_gate_array_reg.sv
// Scoreboard bench for logic_gate_array_reg: driver pushes model results, forked monitor pops on handshake.

module tb_logic_gate_array_reg;
    localparam int WIDTH  = 8;
    localparam int NUM_IN = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       any;
        logic       all;
        logic [7:0] beats;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [2:0]  in_op = '0;
    logic        in_acc = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_any;
    logic        out_all;
    logic [7:0]  out_beats;

    int          checks = 0;
    int          fails = 0;
    int          ready_mode = 0;
    exp_t        sb[$];
    logic [31:0] grp_q[$];
    logic        in_grp = 1'b0;
    logic [2:0]  grp_op_m = '0;
    logic        hold_prev = 1'b0;
    logic [17:0] prev_out = '0;

    logic_gate_array_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_any(out_any), .out_all(out_all), .out_beats(out_beats)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input logic [7:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    // Reference: reduce every channel of every beat in the group with the group's gate.
    function automatic exp_t model(input logic [2:0] op);
        exp_t e;
        logic [7:0] r;
        logic [7:0] c;
        r = (op == 3'd0 || op == 3'd3) ? 8'hFF : 8'h00;
        foreach (grp_q[i])
            for (int k = 0; k < NUM_IN; k++) begin
                c = grp_q[i][k*8 +: 8];
                if (op == 3'd0 || op == 3'd3) r = r & c;
                else if (op == 3'd1 || op == 3'd4) r = r | c;
                else if (op == 3'd2 || op == 3'd5) r = r ^ c;
            end
        if (op == 3'd6) r = grp_q[0][7:0];
        if (op == 3'd7) r = 8'h00;
        if (op >= 3'd3 && op <= 3'd5) r = ~r;
        e.data  = r;
        e.any   = (r != 8'h00);
        e.all   = (r == 8'hFF);
        e.beats = (grp_q.size() > 255) ? 8'd255 : 8'(grp_q.size());
        return e;
    endfunction

    task automatic model_accept(input logic [31:0] d, input logic [2:0] op, input logic acc, input logic last);
        if (!in_grp) begin
            grp_q.delete();
            grp_q.push_back(d);
            if (!acc || last) sb.push_back(model(op));
            else begin
                in_grp   = 1'b1;
                grp_op_m = op;
            end
        end else begin
            grp_q.push_back(d);
            if (last) begin
                sb.push_back(model(grp_op_m));
                in_grp = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else out_ready = (ready_mode == 0);
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] op, input logic acc, input logic last);
        logic ok;
        int   n;
        in_valid = 1'b1; in_data = d; in_op = op; in_acc = acc; in_last = last;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (ok) model_accept(d, op, acc, last);
        else begin
            checks++; fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic check_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_beats !== 8'h00 || in_ready !== 1'b1 ||
            out_any !== 1'b0 || out_all !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got valid=%b data=%h beats=%0d ready=%b any=%b all=%b, required 0 00 0 1 0 0",
                     out_valid, out_data, out_beats, in_ready, out_any, out_all);
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset();
        sb.delete();
        grp_q.delete();
        in_grp = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_drain();
        int n;
        ready_mode = 0;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0 || out_valid) begin
            fails++;
            $display("FAIL drain: %0d results still expected, out_valid=%b, required 0 and 0", sb.size(), out_valid);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 1'b0;
                continue;
            end
            if (hold_prev) begin
                checks++;
                if (out_valid !== 1'b1 || {out_data, out_any, out_all, out_beats} !== prev_out) begin
                    fails++;
                    $display("FAIL hold: got valid=%b out=%h, required 1 %h", out_valid,
                             {out_data, out_any, out_all, out_beats}, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_result: got data=%h beats=%0d, required no result", out_data, out_beats);
                end else begin
                    e = sb.pop_front();
                    if ({out_data, out_any, out_all, out_beats} !== e) begin
                        fails++;
                        $display("FAIL result: got data=%h any=%b all=%b beats=%0d, required data=%h any=%b all=%b beats=%0d",
                                 out_data, out_any, out_all, out_beats, e.data, e.any, e.all, e.beats);
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_out  = {out_data, out_any, out_all, out_beats};
        end
    endtask

    function automatic logic [7:0] rbyte();
        int s;
        s = $urandom_range(0, 5);
        if (s == 0) return 8'hFF;
        if (s == 1) return 8'h00;
        return 8'($urandom);
    endfunction

    initial begin
        fork monitor(); join_none
        #1;
        check_reset();
        repeat (2) tick();
        #1 rst_n = 1'b1;
        tick();

        send(pk(8'h01, 8'h02, 8'h04, 8'h80), 3'b001, 1'b0, 1'b0);
        send(pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), 3'b011, 1'b0, 1'b0);
        send(pk(8'h0F, 8'h00, 8'h00, 8'h00), 3'b010, 1'b1, 1'b0);
        send(pk(8'hF0, 8'h00, 8'h00, 8'h00), 3'b010, 1'b1, 1'b0);
        send(pk(8'h01, 8'h00, 8'h00, 8'h00), 3'b010, 1'b1, 1'b1);
        send(pk(8'h0F, 8'h00, 8'h00, 8'h00), 3'b101, 1'b1, 1'b0);
        send(pk(8'hF0, 8'h00, 8'h00, 8'h00), 3'b101, 1'b1, 1'b0);
        send(pk(8'h01, 8'h00, 8'h00, 8'h00), 3'b101, 1'b1, 1'b1);
        wait_drain();

        // Stall with a pending result, then consume and accept in the same cycle.
        ready_mode = 2;
        tick();
        send(pk(8'h01, 8'h02, 8'h04, 8'h80), 3'b001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h87) begin
                fails++;
                $display("FAIL stall: got ready=%b valid=%b data=%h, required 0 1 87", in_ready, out_valid, out_data);
            end
            tick();
        end
        ready_mode = 0;
        out_ready = 1'b1;
        send(pk(8'h10, 8'h00, 8'h00, 8'h00), 3'b001, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h10) begin
            fails++;
            $display("FAIL back_to_back: got valid=%b data=%h, required 1 10", out_valid, out_data);
        end
        wait_drain();

        send(pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), 3'b000, 1'b1, 1'b0);
        send(pk(8'h0F, 8'hFF, 8'hFF, 8'hFF), 3'b000, 1'b1, 1'b0);
        do_reset();
        send(pk(8'hF0, 8'hFF, 8'hFF, 8'hFF), 3'b000, 1'b0, 1'b0);

        send(pk(8'h01, 8'h00, 8'h00, 8'h00), 3'b001, 1'b1, 1'b0);
        send(pk(8'h01, 8'h01, 8'h01, 8'h01), 3'b000, 1'b0, 1'b0);
        send(pk(8'h02, 8'h00, 8'h00, 8'h00), 3'b000, 1'b1, 1'b1);
        send(pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), 3'b111, 1'b0, 1'b0);
        send(pk(8'hA5, 8'h3C, 8'h00, 8'hFF), 3'b110, 1'b0, 1'b0);

        send(pk(rbyte(), rbyte(), rbyte(), rbyte()), 3'b001, 1'b1, 1'b0);
        for (int i = 0; i < 254; i++) send(pk(rbyte(), 8'h00, 8'h00, 8'h00), 3'b010, 1'b1, 1'b0);
        send(pk(8'h00, 8'h00, 8'h00, 8'h00), 3'b001, 1'b1, 1'b1);
        wait_drain();

        ready_mode = 1;
        for (int i = 0; i < 400; i++) begin
            send(pk(rbyte(), rbyte(), rbyte(), rbyte()), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) tick();
        end
        send(pk(8'h11, 8'h22, 8'h33, 8'h44), 3'b010, 1'b1, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end
endmodule
